ram8_16: RTL and testbench

//   Eight-word x 16-bit synchronous memory; the first stateful consumer of the
//   mux library. DMux8Way fans the write strobe out to one word register.
//   Mux8Way16 selects the read word. Building block for ram64/ram512 and the
//   CPU data memory.

---
 rtl/ram8_16_if.sv | 22 ++
 rtl/ram8_16.sv | 38 +++
 tb/tb_ram8_16.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram8_16_if.sv
// Bus bundle for the 8x16 word memory: write data, write enable, word select
// and the combinational read word.
interface ram8_16_if;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );
endinterface

// File: rtl/ram8_16.sv
// Eight 16-bit word registers with one-hot write steering and a zero-latency
// combinational read of the addressed word; writes become visible after the edge.
module ram8_16 (
  input  logic      clk,
  input  logic      reset,
  ram8_16_if.slave  bus
);
  logic [7:0]       load_sel;
  logic [7:0][15:0] word_q;

  // Fan the write strobe out to exactly one word.
  always_comb begin
    load_sel              = '0;
    load_sel[bus.address] = bus.load;
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_word
      logic [15:0] word_reg;
      logic [15:0] word_next;

      assign word_next = load_sel[gi] ? bus.in : word_reg;

      // Reset takes priority over a write landing on the same edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg <= '0;
        end else begin
          word_reg <= word_next;
        end
      end

      assign word_q[gi] = word_reg;
    end
  endgenerate

  assign bus.out = word_q[bus.address];
endmodule

// File: tb/tb_ram8_16.sv
// Directed and random stimulus for ram8_16 checked against a plain 8x16 array
// model updated with the memory's reset/write rules on every rising edge.
module tb_ram8_16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  ram8_16_if bus ();

  ram8_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] model [8];
  bit          model_valid = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle; the read path must already show the stored word.
  task automatic drive(input logic r, input logic ld, input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    reset       = r;
    bus.load    = ld;
    bus.address = a;
    bus.in      = d;
    #1;
    if (model_valid) check_eq("pre_edge_read", bus.out, model[a]);
  endtask

  // One rising edge: update the model by the memory rules, then compare.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      model_valid = 1'b1;
    end else if (bus.load && model_valid) begin
      model[bus.address] = bus.in;
    end
    #1;
    n_txn++;
    $display("txn %0d reset=%b load=%b addr=%0d in=%h out=%h",
             n_txn, reset, bus.load, bus.address, bus.in, bus.out);
    if (model_valid) check_eq("post_edge_read", bus.out, model[bus.address]);
  endtask

  initial begin
    logic [15:0] exp_word;

    // 1: reset, then every word reads zero
    drive(1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 3'(a), 16'($urandom));
      tick();
      check_eq("s1_reset_zero", bus.out, 16'h0000);
    end

    // 2: write distinct patterns, read back without aliasing
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 3'(k), 16'hA5A0 | 16'(k));
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 3'(a), 16'h0000);
      tick();
      check_eq("s2_readback", bus.out, 16'hA5A0 | 16'(a));
    end

    // 3: read-during-write at the same address
    drive(1'b0, 1'b1, 3'd3, 16'h1111);
    tick();
    drive(1'b0, 1'b1, 3'd3, 16'h2222);
    check_eq("s3_old_before_edge", bus.out, 16'h1111);
    tick();
    check_eq("s3_new_after_edge", bus.out, 16'h2222);

    // 4: hold with load low while data and address toggle
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 3'(a), 16'hFFFF);
      tick();
      exp_word = (a == 3) ? 16'h2222 : (16'hA5A0 | 16'(a));
      check_eq("s4_hold", bus.out, exp_word);
    end

    // 5: reset beats a simultaneous write, then the write goes through
    drive(1'b1, 1'b1, 3'd5, 16'hBEEF);
    tick();
    check_eq("s5_reset_wins", bus.out, 16'h0000);
    drive(1'b0, 1'b1, 3'd5, 16'hBEEF);
    check_eq("s5_zero_before_write", bus.out, 16'h0000);
    tick();
    check_eq("s5_write_after_reset", bus.out, 16'hBEEF);
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 3'(a), 16'h1234);
      tick();
      exp_word = (a == 5) ? 16'hBEEF : 16'h0000;
      check_eq("s5_others_zero", bus.out, exp_word);
    end

    // 6: random traffic with occasional reset
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 99) == 0), 1'($urandom), 3'($urandom), 16'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
